dbus_master: RTL and testbench

Data-bus initiator for the single-cycle/multicycle core. It converts one load/store request from the execute stage into a transfer on the external data bus (DAD, DDT, MREQ, WRITE, SIZE, ACKD_n) and waits any number of cycles for the memory responder's acknowledge. It returns the load data sign- or zero-extended to 32 bits. It rejects misaligned accesses before they reach the bus, and it aborts transfers that are never acknowledged.

---
 rtl/dbus_pkg.sv | 18 +
 rtl/dbus_lane_align.sv | 48 ++++
 rtl/dbus_master.sv | 153 +++++++++++++++
 tb/tb_dbus_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared encodings for the data-bus initiator: FSM states, transfer sizes
// and response codes.
package dbus_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_MISALIGN = 2'b01;
  localparam logic [1:0] RESP_TIMEOUT  = 2'b10;

endpackage

// File: rtl/dbus_lane_align.sv
// Combinational lane handling: alignment check of an incoming request,
// right-aligned store data masking and load sign/zero extension.
// Size 2'b11 falls through to byte handling everywhere.
module dbus_lane_align import dbus_pkg::*; #(
  parameter int BIT_WIDTH = 32
) (
  input  logic [1:0]           req_size,
  input  logic [1:0]           addr_lsb,
  input  logic [BIT_WIDTH-1:0] wdata,
  output logic                 misaligned,
  output logic [BIT_WIDTH-1:0] store_data,
  input  logic [1:0]           ld_size,
  input  logic                 ld_unsigned,
  input  logic [BIT_WIDTH-1:0] ld_raw,
  output logic [BIT_WIDTH-1:0] ld_data
);

  // Halves need an even address, words a 4-byte aligned one.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SIZE_WORD: misaligned = |addr_lsb;
      SIZE_HALF: misaligned = addr_lsb[0];
      default:   misaligned = 1'b0;
    endcase
  end

  // Store data keeps only the lanes of the transfer size, upper lanes zeroed.
  always_comb begin
    store_data = {{(BIT_WIDTH-8){1'b0}}, wdata[7:0]};
    case (req_size)
      SIZE_WORD: store_data = wdata;
      SIZE_HALF: store_data = {{(BIT_WIDTH-16){1'b0}}, wdata[15:0]};
      default:   store_data = {{(BIT_WIDTH-8){1'b0}}, wdata[7:0]};
    endcase
  end

  // Load data is extended from the top bit of its lane unless unsigned.
  always_comb begin
    ld_data = {{(BIT_WIDTH-8){~ld_unsigned & ld_raw[7]}}, ld_raw[7:0]};
    case (ld_size)
      SIZE_WORD: ld_data = ld_raw;
      SIZE_HALF: ld_data = {{(BIT_WIDTH-16){~ld_unsigned & ld_raw[15]}}, ld_raw[15:0]};
      default:   ld_data = {{(BIT_WIDTH-8){~ld_unsigned & ld_raw[7]}}, ld_raw[7:0]};
    endcase
  end

endmodule

// File: rtl/dbus_master.sv
// Data-bus initiator: takes one load/store request, runs it on the external
// bus (DAD/DDT/MREQ/WRITE/SIZE) and waits for ACKD_n, with misalignment
// rejection and an optional acknowledge timeout.
module dbus_master import dbus_pkg::*; #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [1:0]           resp_code,
  output logic [BIT_WIDTH-1:0] DAD,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 ld_unsigned;
  logic [BIT_WIDTH-1:0] wr_data;
  logic                 misaligned;
  logic [BIT_WIDTH-1:0] store_data;
  logic [BIT_WIDTH-1:0] ld_data;
  logic                 latch;
  logic                 mreq_nxt;
  logic                 resp_valid_nxt;
  logic                 resp_err_nxt;
  logic [1:0]           resp_code_nxt;
  logic [BIT_WIDTH-1:0] resp_rdata_nxt;
  logic                 timeout_hit;

  assign req_ready = (state == IDLE);

  // DDT is only driven by us during a store transfer.
  assign DDT = (MREQ && WRITE) ? wr_data : {BIT_WIDTH{1'bz}};

  // The alignment check and store masking look at the incoming request;
  // extension looks at the latched transfer and the live bus data.
  dbus_lane_align #(.BIT_WIDTH(BIT_WIDTH)) u_align (
    .req_size   (req_size),
    .addr_lsb   (req_addr[1:0]),
    .wdata      (req_wdata),
    .misaligned (misaligned),
    .store_data (store_data),
    .ld_size    (SIZE),
    .ld_unsigned(ld_unsigned),
    .ld_raw     (DDT),
    .ld_data    (ld_data)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LIMIT);

  // Next state and next registered outputs; an ack wins over a same-edge timeout.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    latch          = 1'b0;
    mreq_nxt       = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_code_nxt  = RESP_OK;
    resp_rdata_nxt = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_code_nxt  = RESP_MISALIGN;
          end else begin
            state_nxt = BUS;
            mreq_nxt  = 1'b1;
            latch     = 1'b1;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      BUS: begin
        mreq_nxt = 1'b1;
        if (!ACKD_n) begin
          state_nxt      = IDLE;
          mreq_nxt       = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = WRITE ? '0 : ld_data;
          cnt_nxt        = '0;
        end else if (timeout_hit) begin
          state_nxt      = IDLE;
          mreq_nxt       = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
          resp_code_nxt  = RESP_TIMEOUT;
          cnt_nxt        = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Bus outputs, request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MREQ        <= 1'b0;
      WRITE       <= 1'b0;
      SIZE        <= SIZE_WORD;
      DAD         <= '0;
      wr_data     <= '0;
      ld_unsigned <= 1'b0;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_code   <= RESP_OK;
      resp_rdata  <= '0;
    end else begin
      MREQ       <= mreq_nxt;
      cnt        <= cnt_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_code  <= resp_code_nxt;
      resp_rdata <= resp_rdata_nxt;
      if (latch) begin
        DAD         <= req_addr;
        WRITE       <= req_write;
        SIZE        <= req_size;
        ld_unsigned <= req_unsigned;
        wr_data     <= store_data;
      end
    end
  end

endmodule

// File: tb/tb_dbus_master.sv
// Directed bench for dbus_master with a simple responder driving ACKD_n/DDT.
module tb_dbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_code;
  logic [31:0] dad;
  wire  [31:0] ddt;
  logic        mreq;
  logic        write;
  logic [1:0]  size;
  logic        ackd_n;
  logic        rsp_drive;
  logic [31:0] rsp_data;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  assign ddt = rsp_drive ? rsp_data : 32'hzzzz_zzzz;

  dbus_master #(.BIT_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_code(resp_code), .DAD(dad), .DDT(ddt),
    .MREQ(mreq), .WRITE(write), .SIZE(size), .ACKD_n(ackd_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
    checks++;
    assert (obs !== bad) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h must differ from %h", tag, obs, bad);
    end
  endtask

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Responder acks so that ACKD_n is first sampled low n edges after acceptance.
  task automatic ack_after(input int n, input logic drive, input logic [31:0] data);
    for (int i = 1; i < n; i++) tick();
    ackd_n = 1'b0; rsp_drive = drive; rsp_data = data;
    tick();
    ackd_n = 1'b1; rsp_drive = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; ackd_n = 1'b1;
    rsp_drive = 1'b0; rsp_data = '0;
    #3;
    check("rst_mreq", {31'b0, mreq}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_dad", dad, 32'd0);
    check("rst_code", {30'b0, resp_code}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    rst = 1'b1;
    tick();

    // Word load, ack after one cycle.
    check("wl_ready_idle", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0);
    check("wl_mreq", {31'b0, mreq}, 32'd1);
    check("wl_write", {31'b0, write}, 32'd0);
    check("wl_size", {30'b0, size}, 32'd0);
    check("wl_dad", dad, 32'h0800_0010);
    check("wl_ready_bus", {31'b0, req_ready}, 32'd0);
    ack_after(1, 1'b1, 32'h1234_5678);
    check("wl_mreq_fall", {31'b0, mreq}, 32'd0);
    check("wl_valid", {31'b0, resp_valid}, 32'd1);
    check("wl_err", {31'b0, resp_err}, 32'd0);
    check("wl_rdata", resp_rdata, 32'h1234_5678);
    check("wl_ready_resp", {31'b0, req_ready}, 32'd1);

    // Back-to-back: signed byte load issued in the response cycle.
    issue(1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0);
    check("sb_prev_valid_gone", {31'b0, resp_valid}, 32'd0);
    check("sb_size", {30'b0, size}, 32'd2);
    ack_after(1, 1'b1, 32'h0000_0080);
    check("sb_rdata", resp_rdata, 32'hFFFF_FF80);
    tick();

    issue(1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0);
    ack_after(1, 1'b1, 32'hFFFF_FF80);
    check("ub_rdata", resp_rdata, 32'h0000_0080);
    tick();

    issue(1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h0);
    ack_after(1, 1'b1, 32'h0000_8001);
    check("sh_rdata", resp_rdata, 32'hFFFF_8001);
    tick();

    issue(1'b0, 2'b01, 1'b1, 32'h0800_0002, 32'h0);
    ack_after(1, 1'b1, 32'hABCD_8001);
    check("uh_rdata", resp_rdata, 32'h0000_8001);
    tick();

    // Byte store.
    issue(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'hAABB_CC41);
    check("bs_ddt", ddt, 32'h0000_0041);
    check("bs_size", {30'b0, size}, 32'd2);
    check("bs_write", {31'b0, write}, 32'd1);
    ack_after(1, 1'b0, 32'h0);
    check("bs_valid", {31'b0, resp_valid}, 32'd1);
    check("bs_rdata", resp_rdata, 32'h0);
    check_ne("bs_ddt_released", ddt, 32'h0000_0041);
    tick();

    // Half and word stores.
    issue(1'b1, 2'b01, 1'b0, 32'hF000_0002, 32'h1234_BEEF);
    check("hs_ddt", ddt, 32'h0000_BEEF);
    ack_after(2, 1'b0, 32'h0);
    check("hs_valid", {31'b0, resp_valid}, 32'd1);
    tick();
    issue(1'b1, 2'b00, 1'b0, 32'hF000_0004, 32'hDEAD_BEEF);
    check("ws_ddt", ddt, 32'hDEAD_BEEF);
    ack_after(1, 1'b0, 32'h0);
    tick();

    // Misaligned half and word.
    issue(1'b0, 2'b01, 1'b0, 32'h0800_0001, 32'h0);
    check("mh_mreq", {31'b0, mreq}, 32'd0);
    check("mh_valid", {31'b0, resp_valid}, 32'd1);
    check("mh_err", {31'b0, resp_err}, 32'd1);
    check("mh_code", {30'b0, resp_code}, 32'd1);
    tick();
    issue(1'b1, 2'b00, 1'b0, 32'h0800_0002, 32'h5555_5555);
    check("mw_mreq", {31'b0, mreq}, 32'd0);
    check("mw_valid", {31'b0, resp_valid}, 32'd1);
    check("mw_code", {30'b0, resp_code}, 32'd1);
    tick();
    check("mw_pulse_end", {31'b0, resp_valid}, 32'd0);

    // Timeout with ACKD_n held high (TIMEOUT=4).
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0020, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("to_mreq_hold", {31'b0, mreq}, 32'd1);
      tick();
    end
    check("to_mreq_4th", {31'b0, mreq}, 32'd1);
    check("to_no_valid_yet", {31'b0, resp_valid}, 32'd0);
    tick();
    check("to_mreq_fall", {31'b0, mreq}, 32'd0);
    check("to_valid", {31'b0, resp_valid}, 32'd1);
    check("to_err", {31'b0, resp_err}, 32'd1);
    check("to_code", {30'b0, resp_code}, 32'd2);
    check("to_rdata", resp_rdata, 32'h0);
    tick();

    // Ack after 3 cycles completes normally.
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0024, 32'h0);
    ack_after(3, 1'b1, 32'hCAFE_0003);
    check("a3_code", {30'b0, resp_code}, 32'd0);
    check("a3_rdata", resp_rdata, 32'hCAFE_0003);
    tick();

    // Ack on the same edge as the timeout wins.
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0028, 32'h0);
    ack_after(4, 1'b1, 32'h0BAD_F00D);
    check("a4_err", {31'b0, resp_err}, 32'd0);
    check("a4_rdata", resp_rdata, 32'h0BAD_F00D);
    tick();

    // Reset in the middle of a transfer, stale ack in IDLE afterwards.
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0030, 32'h0);
    check("rb_mreq", {31'b0, mreq}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rb_mreq_async", {31'b0, mreq}, 32'd0);
    check("rb_dad_async", dad, 32'h0);
    check("rb_valid_async", {31'b0, resp_valid}, 32'd0);
    ackd_n = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rb_no_resp", {31'b0, resp_valid}, 32'd0);
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0034, 32'h0);
    check("rb_stale_mreq", {31'b0, mreq}, 32'd1);
    check("rb_stale_valid", {31'b0, resp_valid}, 32'd0);
    ackd_n = 1'b1;
    tick();
    check("rb_wait_mreq", {31'b0, mreq}, 32'd1);
    check("rb_wait_valid", {31'b0, resp_valid}, 32'd0);
    ack_after(1, 1'b1, 32'h7777_0001);
    check("rb_done_valid", {31'b0, resp_valid}, 32'd1);
    check("rb_done_rdata", resp_rdata, 32'h7777_0001);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
